// File: rtl/fp_mul_scheduler.sv
// Round-robin scheduler sharing one combinational floating-point multiplier between requesters.
// Optional per-requester sticky flags when FP_MUL_SCHEDULER_STICKY_FLAGS_EN is defined.
module fp_mul_scheduler #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  parameter int NUM_REQUESTERS   = 4,
  localparam int FW  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1,
  localparam int IDW = $clog2(NUM_REQUESTERS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQUESTERS-1:0]    req_valid,
  output logic [NUM_REQUESTERS-1:0]    req_ready,
  input  logic [NUM_REQUESTERS*FW-1:0] req_a,
  input  logic [NUM_REQUESTERS*FW-1:0] req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [IDW-1:0]               resp_id,
  output logic [FW-1:0]                resp_out,
  output logic                         resp_underflow,
  output logic                         resp_overflow,
  output logic                         resp_invalid,
  output logic                         busy
`ifdef FP_MUL_SCHEDULER_STICKY_FLAGS_EN
  ,
  output logic [3*NUM_REQUESTERS-1:0]  sticky_flags,
  input  logic [NUM_REQUESTERS-1:0]    sticky_clear
`endif
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic [IDW:0] NUM_W = (IDW+1)'(NUM_REQUESTERS);

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic           any_valid;
  logic [FW-1:0]  sel_a, sel_b;
  logic [FW-1:0]  op_a, op_b;
  logic [IDW-1:0] id_q;
  logic [FW-1:0]  res_q;
  logic [2:0]     flags_q;
  logic [FW-1:0]  mul_out;
  logic           mul_unf, mul_ovf, mul_inv;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    any_valid = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQUESTERS; k++) begin
      logic [IDW:0] sum;
      sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (sum >= NUM_W) sum = sum - NUM_W;
      if (!any_valid && req_valid[sum[IDW-1:0]]) begin
        any_valid = 1'b1;
        grant_id  = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = req_a[i*FW +: FW];
        sel_b = req_b[i*FW +: FW];
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is a function of req_valid (one-hot grant in IDLE only); requesters must not
  // make req_valid depend on req_ready. resp_valid holds with stable fields until resp_ready.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid && rst_n) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_valid) state_next = CALC;
      CALC:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= IDW'(NUM_REQUESTERS - 1);
      op_a    <= '0;
      op_b    <= '0;
      id_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      if (state == IDLE && any_valid) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        id_q   <= grant_id;
        rr_ptr <= grant_id;
      end
      if (state == CALC) begin
        res_q   <= mul_out;
        flags_q <= {mul_inv, mul_ovf, mul_unf};
      end
    end
  end

  assign resp_valid     = (state == RESP);
  assign busy           = (state != IDLE);
  assign resp_id        = id_q;
  assign resp_out       = res_q;
  assign resp_invalid   = flags_q[2];
  assign resp_overflow  = flags_q[1];
  assign resp_underflow = flags_q[0];

`ifdef FP_MUL_SCHEDULER_STICKY_FLAGS_EN
  logic [3*NUM_REQUESTERS-1:0] sticky_q;

  // A set on the same edge as a clear wins: the OR is applied to the cleared value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQUESTERS; i++) begin
        if (sticky_clear[i]) sticky_q[3*i +: 3] <= 3'b000;
        if (state == CALC && id_q == IDW'(i))
          sticky_q[3*i +: 3] <= (sticky_clear[i] ? 3'b000 : sticky_q[3*i +: 3]) |
                                {mul_inv, mul_ovf, mul_unf};
      end
    end
  end

  assign sticky_flags = sticky_q;
`endif

  floating_point_multiplier #(
    .EXPONENT_WIDTH   (EXPONENT_WIDTH),
    .MANTISSA_WIDTH   (MANTISSA_WIDTH),
    .ROUND_TO_NEAREST (ROUND_TO_NEAREST)
  ) u_mul (
    .a                 (op_a),
    .b                 (op_b),
    .out               (mul_out),
    .underflow         (mul_unf),
    .overflow          (mul_ovf),
    .invalid_operation (mul_inv)
  );

endmodule

// Combinational multiplier: subnormal inputs are treated as zero, subnormal results flush to zero.
module floating_point_multiplier #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1,
  localparam int FW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1
) (
  input  logic [FW-1:0] a,
  input  logic [FW-1:0] b,
  output logic [FW-1:0] out,
  output logic          underflow,
  output logic          overflow,
  output logic          invalid_operation
);

  localparam int EW = EXPONENT_WIDTH;
  localparam int MW = MANTISSA_WIDTH;
  localparam logic [EW+1:0] BIAS_X = (EW+2)'(2**(EW-1) - 1);
  localparam logic [EW+1:0] OVF_X  = (EW+2)'(2**(EW-1) - 1 + 2**EW - 1);
  localparam logic [EW-1:0] BIAS_E = EW'(2**(EW-1) - 1);

  logic          sign;
  logic [EW-1:0] ea, eb;
  logic [MW-1:0] fa, fb;
  logic          a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [2*MW+1:0] prod;
  logic          hi, guard, sticky, round_up, carry;
  logic [MW-1:0] frac_pre, frac_fin;
  logic [EW+1:0] e_biased;

  assign sign   = a[FW-1] ^ b[FW-1];
  assign ea     = a[FW-2 -: EW];
  assign eb     = b[FW-2 -: EW];
  assign fa     = a[MW-1:0];
  assign fb     = b[MW-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_nan  = (&eb) && (fb != '0);

  // Significand product lies in [1,4); hi selects the one-bit normalising shift.
  assign prod     = {{(MW+1){1'b0}}, 1'b1, fa} * {{(MW+1){1'b0}}, 1'b1, fb};
  assign hi       = prod[2*MW+1];
  assign frac_pre = hi ? prod[2*MW -: MW] : prod[2*MW-1 -: MW];
  assign guard    = hi ? prod[MW] : prod[MW-1];
  assign sticky   = hi ? |prod[MW-1:0] : |prod[MW-2:0];
  assign round_up = (ROUND_TO_NEAREST != 0) && guard && (sticky || frac_pre[0]);
  assign {carry, frac_fin} = {1'b0, frac_pre} + {{MW{1'b0}}, round_up};
  assign e_biased = {2'b00, ea} + {2'b00, eb} + {{(EW+1){1'b0}}, hi} + {{(EW+1){1'b0}}, carry};

  always_comb begin
    out               = {sign, e_biased[EW-1:0] - BIAS_E, frac_fin};
    underflow         = 1'b0;
    overflow          = 1'b0;
    invalid_operation = 1'b0;
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      out               = {1'b1, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      invalid_operation = 1'b1;
    end else if (a_inf || b_inf) begin
      out = {sign, {EW{1'b1}}, {MW{1'b0}}};
    end else if (a_zero || b_zero) begin
      out = {sign, {(EW+MW){1'b0}}};
    end else if (e_biased >= OVF_X) begin
      out      = {sign, {EW{1'b1}}, {MW{1'b0}}};
      overflow = 1'b1;
    end else if (e_biased <= BIAS_X) begin
      out       = {sign, {(EW+MW){1'b0}}};
      underflow = 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler (FP32, four requesters) against an arithmetic reference model.
module tb_fp_mul_scheduler;

  localparam int N  = 4;
  localparam int FW = 32;
  localparam int ROUND_TO_NEAREST = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*FW-1:0] req_a = '0;
  logic [N*FW-1:0] req_b = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [1:0]      resp_id;
  logic [FW-1:0]   resp_out;
  logic            resp_underflow, resp_overflow, resp_invalid;
  logic            busy;
`ifdef FP_MUL_SCHEDULER_STICKY_FLAGS_EN
  logic [3*N-1:0]  sticky_flags;
  logic [N-1:0]    sticky_clear = '0;
`endif

  int checks = 0;
  int errors = 0;
  int last_grant = N - 1;
  logic [34:0] exp_q[$];
  int          exp_id_q[$];

  fp_mul_scheduler #(
    .EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23),
    .ROUND_TO_NEAREST(ROUND_TO_NEAREST), .NUM_REQUESTERS(N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_out(resp_out), .resp_underflow(resp_underflow),
    .resp_overflow(resp_overflow), .resp_invalid(resp_invalid), .busy(busy)
`ifdef FP_MUL_SCHEDULER_STICKY_FLAGS_EN
    , .sticky_flags(sticky_flags), .sticky_clear(sticky_clear)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Exact significand product, scaled to a 24-bit integer, rounded half-to-even.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    int ea, eb, e, k;
    longint unsigned p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return {3'b100, 32'hFFC00000};
    if (a_inf || b_inf) return {3'b000, s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {3'b000, s, 31'h0};
    p = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    k = (p >= 64'h8000_0000_0000) ? 24 : 23;
    q = p >> k;
    rem  = p - (q << k);
    half = 64'd1 << (k - 1);
    e = ea + eb - 127 + (k - 23);
    if (ROUND_TO_NEAREST != 0 && (rem > half || (rem == half && q[0]))) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0) return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), q[22:0]};
  endfunction

  function automatic int next_grant(input int last, input logic [N-1:0] valid);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] rand_operand();
    int c;
    logic s;
    logic [7:0] e;
    logic [22:0] m;
    c = $urandom_range(0, 9);
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case (c)
      5:       e = 8'($urandom_range(1, 30));
      6:       e = 8'($urandom_range(220, 254));
      7:       e = 8'd0;
      8:       begin e = 8'hFF; m = 23'd0; end
      9:       e = 8'hFF;
      default: e = 8'($urandom_range(90, 165));
    endcase
    return {s, e, m};
  endfunction

  function automatic logic [34:0] observed();
    return {resp_invalid, resp_overflow, resp_underflow, resp_out};
  endfunction

  // ---------------- driver: one isolated transaction ----------------
  task automatic run_one(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [34:0] expv, input string name);
    int n;
    logic [34:0] want;
    req_a[id*FW +: FW] = a;
    req_b[id*FW +: FW] = b;
    req_valid = '0;
    req_valid[id] = 1'b1;
    resp_ready = 1'b1;
    #1;
    n = 0;
    while (req_ready === '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== req_valid) begin
      errors++;
      $display("FAIL %s grant: req_ready=%b expected %b", name, req_ready, req_valid);
    end
    last_grant = id;
    exp_q.push_back(expv);
    tick();
    req_valid = '0;
    req_a[id*FW +: FW] = $urandom;
    req_b[id*FW +: FW] = $urandom;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s calc: resp_valid=%b busy=%b expected 0/1", name, resp_valid, busy);
    end
    tick();
    want = exp_q.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'(id)) begin
      errors++;
      $display("FAIL %s resp: resp_valid=%b resp_id=%0d expected 1/%0d", name, resp_valid, resp_id, id);
    end
    checks++;
    if (observed() !== want) begin
      errors++;
      $display("FAIL %s data: a=%h b=%h got flags/out=%h expected %h", name, a, b, observed(), want);
    end
    tick();
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: resp_valid=%b busy=%b expected 0/0", name, resp_valid, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    checks++;
    if ({resp_valid, busy, req_ready, resp_id, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {resp_valid, busy, req_ready, resp_id, observed()});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    int got = 0, grants = 0, prev_cycle = 0, cycle = 0, g, eid;
    logic [34:0] want;
    for (int i = 0; i < 3; i++) begin
      req_a[i*FW +: FW] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
      req_b[i*FW +: FW] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
    end
    req_valid = 4'b0111;
    resp_ready = 1'b1;
    #1;
    while (got < 5 && cycle < 40) begin
      if (req_ready !== '0) begin
        g = next_grant(last_grant, req_valid);
        checks++;
        if (req_ready !== (4'b0001 << g)) begin
          errors++;
          $display("FAIL rr_grant: req_ready=%b expected grant %0d", req_ready, g);
        end
        exp_q.push_back(ref_mul(req_a[g*FW +: FW], req_b[g*FW +: FW]));
        exp_id_q.push_back(g);
        last_grant = g;
        grants++;
      end
      if (resp_valid === 1'b1 && exp_q.size() > 0) begin
        want = exp_q.pop_front();
        eid = exp_id_q.pop_front();
        checks++;
        if (resp_id !== 2'(eid) || observed() !== want) begin
          errors++;
          $display("FAIL rr_resp: id=%0d out=%h expected id=%0d out=%h", resp_id, observed(), eid, want);
        end
        if (got > 0) begin
          checks++;
          if (cycle - prev_cycle != 3) begin
            errors++;
            $display("FAIL rr_spacing: %0d cycles between responses expected 3", cycle - prev_cycle);
          end
        end
        prev_cycle = cycle;
        got++;
        if (got == 5) req_valid = '0;
      end
      tick();
      cycle++;
    end
    checks++;
    if (got != 5 || grants != 5) begin
      errors++;
      $display("FAIL rr_count: responses=%0d grants=%0d expected 5/5", got, grants);
    end
    exp_q.delete();
    exp_id_q.delete();
  endtask

  task automatic test_basic();
    run_one(1, 32'h3FC00000, 32'h40000000, {3'b000, 32'h40400000}, "basic");
  endtask

  task automatic test_special();
    logic [31:0] ta[4] = '{32'h7F000000, 32'h00800000, 32'h00000000, 32'h7FC00000};
    logic [31:0] tb[4] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'h3F800000};
    logic [34:0] te[4] = '{{3'b010, 32'h7F800000}, {3'b001, 32'h00000000},
                           {3'b100, 32'hFFC00000}, {3'b100, 32'hFFC00000}};
    for (int i = 0; i < 4; i++) run_one(int'($urandom_range(0, N-1)), ta[i], tb[i], te[i], "special");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = rand_operand();
      b = rand_operand();
      run_one(int'($urandom_range(0, N-1)), a, b, ref_mul(a, b), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] want;
    int g;
    req_a[2*FW +: FW] = 32'h40490FDB;
    req_b[2*FW +: FW] = 32'h3F3504F3;
    want = ref_mul(32'h40490FDB, 32'h3F3504F3);
    req_valid = 4'b0100;
    resp_ready = 1'b0;
    #1;
    last_grant = 2;
    tick();
    req_valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      req_valid = 4'b1111;
      #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== '0 || resp_id !== 2'd2 || observed() !== want) begin
        errors++;
        $display("FAIL hold: valid=%b ready=%b id=%0d out=%h expected 1/0000/2/%h",
                 resp_valid, req_ready, resp_id, observed(), want);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    g = next_grant(last_grant, req_valid);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== (4'b0001 << g)) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b expected 0/grant %0d", resp_valid, req_ready, g);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    req_a[3*FW +: FW] = 32'h3FC00000;
    req_b[3*FW +: FW] = 32'h3FC00000;
    req_valid = 4'b1000;
    resp_ready = 1'b1;
    #1;
    tick();
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({resp_valid, busy, req_ready, resp_id, observed()} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {resp_valid, busy, req_ready, resp_id, observed()});
    end
    last_grant = N - 1;
    #2;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== (4'b0001 << next_grant(last_grant, req_valid))) begin
      errors++;
      $display("FAIL reset_first_grant: req_ready=%b expected 0001", req_ready);
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale: resp_valid=%b busy=%b expected 0/0", resp_valid, busy);
      end
    end
    run_one(0, 32'h40000000, 32'h40400000, ref_mul(32'h40000000, 32'h40400000), "after_reset");
  endtask

`ifdef FP_MUL_SCHEDULER_STICKY_FLAGS_EN
  task automatic test_sticky();
    sticky_clear = '1;
    tick();
    sticky_clear = '0;
    checks++;
    if (sticky_flags !== '0) begin
      errors++;
      $display("FAIL sticky_clear_all: got %h expected 0", sticky_flags);
    end
    run_one(1, 32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000}, "sticky_ovf");
    checks++;
    if (sticky_flags !== 12'h010) begin
      errors++;
      $display("FAIL sticky_set: got %h expected 010", sticky_flags);
    end
    sticky_clear = 4'b0010;
    tick();
    sticky_clear = '0;
    checks++;
    if (sticky_flags !== '0) begin
      errors++;
      $display("FAIL sticky_clear: got %h expected 0", sticky_flags);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_basic();
    test_special();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef FP_MUL_SCHEDULER_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_scheduler.md
Name: fp_mul_scheduler

Overview:
- Shares one combinational floating_point_multiplier instance between NUM_REQUESTERS requesters.
- Round-robin arbitration, registered operand capture, registered result and flags.
- Per-requester valid/ready request and response handshakes.
- Sits between datapath clients (e.g. dot-product lanes) and the single multiplier, so the design instantiates only one multiplier.

Parameters:
- EXPONENT_WIDTH, 8, exponent width passed to the multiplier
- MANTISSA_WIDTH, 23, mantissa width passed to the multiplier
- ROUND_TO_NEAREST, 1, passed to the multiplier (0 = chop, 1 = nearest)
- NUM_REQUESTERS, 4, number of requesters (2..16)
- Derived localparams: FW = EXPONENT_WIDTH+MANTISSA_WIDTH+1; IDW = $clog2(NUM_REQUESTERS)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQUESTERS  per-requester request valid
- req_ready  out  NUM_REQUESTERS  per-requester accept (one-hot grant or zero)
- req_a  in  NUM_REQUESTERS*FW  flattened operand A; requester i uses bits [i*FW +: FW]
- req_b  in  NUM_REQUESTERS*FW  flattened operand B, same packing as req_a
- resp_valid  out  1  result valid
- resp_ready  in  1  result consumer ready
- resp_id  out  IDW  index of the requester that owns the result
- resp_out  out  FW  product
- resp_underflow  out  1  multiplier underflow flag for this result
- resp_overflow  out  1  multiplier overflow flag for this result
- resp_invalid  out  1  multiplier invalid_operation flag for this result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (all asynchronous on rst_n low):
  - state = IDLE; all outputs 0.
  - Internal operand, result and id registers = 0.
  - rr_ptr = NUM_REQUESTERS-1, so requester 0 has first priority after reset.
- State machine: IDLE -> CALC -> RESP -> IDLE.
- IDLE:
  - Grant g = first i with req_valid[i] set, scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQUESTERS.
  - req_ready = onehot(g) combinationally; 0 if no req_valid bit is set.
  - req_ready depends on req_valid but req_valid must never depend on req_ready.
  - On a handshake: latch req_a[g], req_b[g] and g into operand/id registers; rr_ptr <= g; go to CALC.
  - With no request, stay in IDLE.
- CALC:
  - req_ready = 0.
  - Multiplier sees the latched operands.
  - At the clock edge, register out and the three flags into result registers; go to RESP.
- RESP:
  - resp_valid = 1; resp_id, resp_out and flags come from registers and stay stable while resp_ready is low.
  - req_ready = 0.
  - When resp_valid && resp_ready: go to IDLE, resp_valid drops next cycle.
  - No bypass from RESP straight to a new grant.
- Timing:
  - Latency from request handshake to resp_valid = 2 cycles.
  - Maximum throughput = 1 result per 3 cycles when resp_ready is held high.
- Request rules:
  - A requester must hold req_valid and its operands stable until it sees req_ready.
  - Operand changes after the handshake have no effect on the result in flight.
- Simultaneous requests: exactly one grant per IDLE cycle. Starvation-free: each waiting requester is served within NUM_REQUESTERS grants.
- rr_ptr wraps from NUM_REQUESTERS-1 to 0.
- Flags are the multiplier's flags, unmodified, registered alongside the result.
- Reset while in CALC or RESP: the transaction is dropped and outputs return to reset values immediately (asynchronous). No response is produced afterwards.
- resp_ready high while resp_valid is low: ignored.

Optional Feature:
- Macro: FP_MUL_SCHEDULER_STICKY_FLAGS_EN.
- When defined, add ports:
  - sticky_flags  out  3*NUM_REQUESTERS  per-requester {invalid, overflow, underflow} at bits [3*i +: 3]
  - sticky_clear  in  NUM_REQUESTERS  per-requester clear
- Sticky bits OR in the result flags at the same CALC->RESP edge, for the granted requester.
- sticky_clear[i] clears requester i's bits; when it coincides with a set in the same cycle, the set wins.
- Sticky bits reset to 0.
- When the macro is not defined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- FP32, requester 1 only: a=0x3FC00000, b=0x40000000 -> resp_valid 2 cycles after handshake; resp_out=0x40400000, resp_id=1, all flags 0.
- Requesters 0, 1 and 2 all valid continuously with resp_ready=1 -> grant order 0,1,2,0,1; each response arrives 3 cycles after the previous one; resp_id matches the grant.
- a=0x7F000000, b=0x7F000000 -> resp_out=0x7F800000, resp_overflow=1. a=0x00800000, b=0x00800000 -> resp_out=0x00000000, resp_underflow=1.
- a=0x00000000, b=0x7F800000 -> resp_out=0xFFC00000, resp_invalid=1. a=0x7FC00000, b=0x3F800000 -> resp_out=0xFFC00000, resp_invalid=1.
- Hold resp_ready=0 for 5 cycles while in RESP, change req_a/req_b and assert other req_valid bits -> response fields unchanged, req_ready stays 0, no grant until the response handshake completes.
- Assert rst_n low during CALC -> outputs are 0 immediately; after release, requester 0 wins first and no stale response appears. With FP_MUL_SCHEDULER_STICKY_FLAGS_EN defined: the overflow case sets requester's sticky overflow bit; sticky_clear clears it.
